bus_read_fifo: RTL

Receive-side endpoint of the shared 32-bit CPU data bus: captures the word currently driven onto the bus by the active tri-state bus buffer whenever the load strobe is asserted. Captured words are queued in a small synchronous FIFO and presented to the consuming stage (register file write port, memory data register) through a valid/read handshake. This decouples the cycle on which a source drives the bus from the cycle on which the sink consumes the word.

---
 rtl/bus_read_fifo_if.sv | 30 +++
 rtl/bus_read_fifo.sv | 84 ++++++++
 2 files changed

// File: rtl/bus_read_fifo_if.sv
// Bus-read FIFO handshake interface.
// Groups the capture side (ld, bus_in) and the consumer side (rd, dout, valid)
// together with the status outputs (full, count, ovf).
//   slave  modport: used by the FIFO (inputs ld/rd/bus_in; outputs the rest)
//   master modport: used by whatever drives the bus and consumes words
interface bus_read_fifo_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] bus_in;  // shared bus value
  logic             ld;      // capture strobe
  logic             rd;      // consumer pop
  logic [WIDTH-1:0] dout;    // head word, 0 when empty
  logic             valid;   // FIFO not empty
  logic             full;    // count == DEPTH
  logic [CntW-1:0]  count;   // stored words, 0..DEPTH
  logic             ovf;     // sticky overflow flag

  modport slave (
    input  bus_in, ld, rd,
    output dout, valid, full, count, ovf
  );

  modport master (
    output bus_in, ld, rd,
    input  dout, valid, full, count, ovf
  );
endinterface

// File: rtl/bus_read_fifo.sv
// Receive-side endpoint of the shared CPU data bus. Captures bus_in whenever
// ld is high and queues it in a DEPTH-entry FIFO; the consumer pops with rd.
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset
//   bus_if - bus_read_fifo_if.slave: bus_in, ld, rd in; dout, valid, full,
//            count, ovf out
// Optional feature: define BUS_READ_FIFO_OVF_FLAG_EN to build the sticky
// overflow flag; otherwise ovf is tied to 0. Drop-on-full behaviour is the
// same in both builds.
module bus_read_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  bus_read_fifo_if.slave bus_if
);
  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = AddrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW-1:0] wptr_q, wptr_d;
  logic [AddrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             valid, full, push, pop;

  assign valid = (count_q != '0);
  assign full  = (count_q == CntW'(DEPTH));

  // A full FIFO still accepts a word when the head is popped on the same edge.
  assign pop  = bus_if.rd & valid;
  assign push = bus_if.ld & (~full | bus_if.rd);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + AddrW'(1);
    if (pop)  rptr_d = rptr_q + AddrW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is never reset; stale entries are hidden by the valid gate on dout.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus_if.bus_in;
  end

`ifdef BUS_READ_FIFO_OVF_FLAG_EN
  logic ovf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (bus_if.ld && full && !bus_if.rd) begin
      ovf_q <= 1'b1;
    end
  end
  assign bus_if.ovf = ovf_q;
`else
  assign bus_if.ovf = 1'b0;
`endif

  // Outputs decode registered state only.
  assign bus_if.dout  = valid ? mem_q[rptr_q] : '0;
  assign bus_if.valid = valid;
  assign bus_if.full  = full;
  assign bus_if.count = count_q;
endmodule
